// File: rtl/single_cycle_datapath.sv
// -----------------------------------------------------------------------------
// single_cycle_datapath
//   Single-cycle 32-bit MIPS-subset CPU core. Each instruction is fetched,
//   decoded, executed and retired in one clock. Instruction memory, register
//   bank and data memory are preloaded from outside by hierarchical reference
//   (instructionMem.memory, RB.MEM, DataMem.MEM). None of them is cleared.
//
// Ports:
//   clk            in   1   system clock, all state changes on rising edge
//   rst            in   1   synchronous active-high reset (PC <= 0, no writes)
//   pc_out         out  32  current PC (byte address)
//   instr_out      out  32  instruction fetched at current PC
//   alu_result_out out  32  current ALU result
//
// Supported: add sub and or slt (R-type), addi slti andi ori lw sw beq bne j.
// Any other opcode/funct executes as a NOP (no writes, PC + 4).
// -----------------------------------------------------------------------------

// Combinational-read instruction ROM; contents loaded hierarchically.
module instruction_memory #(
    parameter int DEPTH = 256
) (
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    output logic [31:0]              data_o
);
    logic [31:0] memory [0:DEPTH-1];

    assign data_o = memory[addr_i];
endmodule

// 32 x 32 register bank: two combinational reads, one clocked write.
// Register 0 reads as zero and ignores writes.
module register_bank (
    input  logic        clk,
    input  logic        we_i,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o
);
    logic [31:0] MEM [0:31];

    assign rs_data_o = (rs_addr_i == 5'd0) ? 32'd0 : MEM[rs_addr_i];
    assign rt_data_o = (rt_addr_i == 5'd0) ? 32'd0 : MEM[rt_addr_i];

    // NOTE: storage arrays carry no reset; a reset loop would turn them into
    // flops with a huge reset fan-out and would wipe the preloaded contents.
    always_ff @(posedge clk) begin
        if (we_i && (wr_addr_i != 5'd0)) begin
            MEM[wr_addr_i] <= wr_data_i;
        end
    end
endmodule

// Word-addressed data memory: combinational read, clocked write.
module data_memory #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wr_data_i,
    output logic [31:0]              rd_data_o
);
    logic [31:0] MEM [0:DEPTH-1];

    assign rd_data_o = MEM[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            MEM[addr_i] <= wr_data_i;
        end
    end
endmodule

module single_cycle_datapath #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic [31:0] alu_result_out
);
    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A,
                           OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LW   = 6'h23,
                           OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    logic [31:0] pc_q, pc_d, pc_plus4, instr;
    logic [31:0] rs_data, rt_data, imm_ext, alu_b, alu_result, dmem_rdata, wb_data;
    logic [4:0]  wr_addr;
    logic        alu_zero;

    // Decoded control
    logic    reg_write, reg_dst, alu_src, imm_zext, mem_write, mem_to_reg;
    logic    branch_eq, branch_ne, jump;
    alu_op_e alu_op;

    // Shift amount field is not used by any supported instruction.
    logic unused_shamt;
    assign unused_shamt = ^instr[10:6];

    // ---------------- Fetch ----------------
    instruction_memory #(.DEPTH(IMEM_DEPTH)) instructionMem (
        .addr_i (pc_q[IA+1:2]),
        .data_o (instr)
    );

    // ---------------- Decode ----------------
    always_comb begin
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        imm_zext   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        jump       = 1'b0;
        alu_op     = ALU_ADD;
        unique case (instr[31:26])
            OP_RTYPE: begin
                reg_dst = 1'b1;
                // Unknown funct leaves reg_write low, i.e. a NOP.
                case (instr[5:0])
                    FN_ADD:  begin reg_write = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB:  begin reg_write = 1'b1; alu_op = ALU_SUB; end
                    FN_AND:  begin reg_write = 1'b1; alu_op = ALU_AND; end
                    FN_OR:   begin reg_write = 1'b1; alu_op = ALU_OR;  end
                    FN_SLT:  begin reg_write = 1'b1; alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_ADDI: begin reg_write = 1'b1; alu_src = 1'b1; end
            OP_SLTI: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_SLT; end
            OP_ANDI: begin reg_write = 1'b1; alu_src = 1'b1; imm_zext = 1'b1; alu_op = ALU_AND; end
            OP_ORI:  begin reg_write = 1'b1; alu_src = 1'b1; imm_zext = 1'b1; alu_op = ALU_OR;  end
            OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1; end
            OP_SW:   begin mem_write = 1'b1; alu_src = 1'b1; end
            OP_BEQ:  begin branch_eq = 1'b1; alu_op = ALU_SUB; end
            OP_BNE:  begin branch_ne = 1'b1; alu_op = ALU_SUB; end
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Register bank ----------------
    assign wr_addr = reg_dst ? instr[15:11] : instr[20:16];
    assign wb_data = mem_to_reg ? dmem_rdata : alu_result;

    // Reset suppresses every architectural write in its cycle.
    register_bank RB (
        .clk       (clk),
        .we_i      (reg_write & ~rst),
        .rs_addr_i (instr[25:21]),
        .rt_addr_i (instr[20:16]),
        .wr_addr_i (wr_addr),
        .wr_data_i (wb_data),
        .rs_data_o (rs_data),
        .rt_data_o (rt_data)
    );

    // ---------------- Execute ----------------
    assign imm_ext = imm_zext ? {16'd0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign alu_b   = alu_src ? imm_ext : rt_data;

    always_comb begin
        alu_result = 32'd0;
        unique case (alu_op)
            ALU_ADD: alu_result = rs_data + alu_b;
            ALU_SUB: alu_result = rs_data - alu_b;
            ALU_AND: alu_result = rs_data & alu_b;
            ALU_OR:  alu_result = rs_data | alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(rs_data) < $signed(alu_b)};
            default: alu_result = 32'd0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

    // ---------------- Data memory ----------------
    data_memory #(.DEPTH(DMEM_DEPTH)) DataMem (
        .clk       (clk),
        .we_i      (mem_write & ~rst),
        .addr_i    (alu_result[DA+1:2]),
        .wr_data_i (rt_data),
        .rd_data_o (dmem_rdata)
    );

    // ---------------- Next PC ----------------
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_plus4;
        if (jump) begin
            pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if ((branch_eq && alu_zero) || (branch_ne && !alu_zero)) begin
            pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) pc_q <= 32'd0;
        else     pc_q <= pc_d;
    end

    assign pc_out         = pc_q;
    assign instr_out      = instr;
    assign alu_result_out = alu_result;
endmodule

// File: tb/tb_single_cycle_datapath.sv
// -----------------------------------------------------------------------------
// Testbench for single_cycle_datapath. A behavioural instruction-set model
// (plain arrays + per-opcode arithmetic) runs in lock-step with the DUT.
// Directed programs cover the named scenarios; random programs follow.
// All bench activity happens on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_single_cycle_datapath;
    localparam int IMEM_DEPTH = 256;
    localparam int DMEM_DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_out, instr_out, alu_result_out;

    single_cycle_datapath #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .alu_result_out (alu_result_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_reg  [32];
    logic [31:0] m_dmem [DMEM_DEPTH];
    logic [31:0] m_imem [IMEM_DEPTH];
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- Encoders ----------------
    function automatic logic [31:0] r_type(input int funct, input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_type(input int target);
        return {6'h02, 26'(target)};
    endfunction

    // ---------------- Reference model ----------------
    function automatic logic [31:0] rd_reg(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : m_reg[r];
    endfunction

    function automatic int imem_idx(input logic [31:0] addr);
        return int'((addr >> 2) % IMEM_DEPTH);
    endfunction

    function automatic int dmem_idx(input logic [31:0] addr);
        return int'((addr >> 2) % DMEM_DEPTH);
    endfunction

    // Execute the instruction at m_pc. Reports the ALU value the spec pins
    // down (arithmetic result or load/store address) when there is one.
    task automatic model_exec(output bit alu_valid, output logic [31:0] alu_exp);
        logic [31:0] w, a, b, se, ze, pc4, res, addr;
        logic [4:0]  rs, rt, rd;
        bit          wr;
        w   = m_imem[imem_idx(m_pc)];
        rs  = w[25:21];
        rt  = w[20:16];
        rd  = w[15:11];
        a   = rd_reg(rs);
        b   = rd_reg(rt);
        se  = 32'($signed(w[15:0]));
        ze  = {16'd0, w[15:0]};
        pc4 = m_pc + 32'd4;
        alu_valid = 1'b0;
        alu_exp   = 32'd0;
        wr  = 1'b0;
        res = 32'd0;
        m_pc = pc4;
        case (w[31:26])
            6'h00: begin
                wr = 1'b1;
                case (w[5:0])
                    6'h20:   res = a + b;
                    6'h22:   res = a - b;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
                if (wr && rd != 5'd0) m_reg[rd] = res;
                alu_valid = wr;
                alu_exp   = res;
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D: begin
                case (w[31:26])
                    6'h08:   res = a + se;
                    6'h0A:   res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
                    6'h0C:   res = a & ze;
                    default: res = a | ze;
                endcase
                if (rt != 5'd0) m_reg[rt] = res;
                alu_valid = 1'b1;
                alu_exp   = res;
            end
            6'h23: begin
                addr = a + se;
                if (rt != 5'd0) m_reg[rt] = m_dmem[dmem_idx(addr)];
                alu_valid = 1'b1;
                alu_exp   = addr;
            end
            6'h2B: begin
                addr = a + se;
                m_dmem[dmem_idx(addr)] = b;
                alu_valid = 1'b1;
                alu_exp   = addr;
            end
            6'h04: if (a == b) m_pc = pc4 + (se << 2);
            6'h05: if (a != b) m_pc = pc4 + (se << 2);
            6'h02: m_pc = {pc4[31:28], w[25:0], 2'b00};
            default: ;
        endcase
    endtask

    // ---------------- Loading helpers (call with rst held high) ----------------
    task automatic set_instr(input int i, input logic [31:0] w);
        dut.instructionMem.memory[i] = w;
        m_imem[i] = w;
    endtask

    task automatic set_reg(input int i, input logic [31:0] v);
        dut.RB.MEM[i] = v;
        m_reg[i] = v;
    endtask

    task automatic set_dmem(input int i, input logic [31:0] v);
        dut.DataMem.MEM[i] = v;
        m_dmem[i] = v;
    endtask

    task automatic clear_state();
        for (int i = 0; i < IMEM_DEPTH; i++) set_instr(i, 32'd0);
        for (int i = 0; i < 32; i++)         set_reg(i, 32'd0);
        for (int i = 0; i < DMEM_DEPTH; i++) set_dmem(i, 32'd0);
    endtask

    // All sequencing tasks start and end on a falling edge.
    task automatic enter_reset();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic leave_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("pc_in_reset", pc_out, 32'd0);
        end
        rst  = 1'b0;
        m_pc = 32'd0;
    endtask

    task automatic step(input int n);
        bit          v;
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            check("pc", pc_out, m_pc);
            check("instr", instr_out, m_imem[imem_idx(m_pc)]);
            model_exec(v, e);
            if (v) check("alu", alu_result_out, e);
            @(negedge clk);
        end
    endtask

    task automatic compare_state(input string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_reg%0d", tag, i), dut.RB.MEM[i], m_reg[i]);
        for (int i = 0; i < DMEM_DEPTH; i++)
            check($sformatf("%s_dmem%0d", tag, i), dut.DataMem.MEM[i], m_dmem[i]);
    endtask

    function automatic logic [31:0] rand_instr();
        int          k    = int'($urandom_range(0, 15));
        int          rs   = int'($urandom_range(0, 31));
        int          rt   = int'($urandom_range(0, 31));
        int          rd   = int'($urandom_range(0, 31));
        int          imm  = int'($urandom_range(0, 65535));
        int          boff = int'($urandom_range(0, 14)) - 7;
        logic [31:0] r    = $urandom;
        case (k)
            0:  return r_type(6'h20, rs, rt, rd);
            1:  return r_type(6'h22, rs, rt, rd);
            2:  return r_type(6'h24, rs, rt, rd);
            3:  return r_type(6'h25, rs, rt, rd);
            4:  return r_type(6'h2A, rs, rt, rd);
            5:  return i_type(6'h08, rs, rt, imm);
            6:  return i_type(6'h0A, rs, rt, imm);
            7:  return i_type(6'h0C, rs, rt, imm);
            8:  return i_type(6'h0D, rs, rt, imm);
            9:  return i_type(6'h23, rs, rt, imm);
            10: return i_type(6'h2B, rs, rt, imm);
            11: return i_type(6'h04, rs, (r[0] ? rs : rt), boff);
            12: return i_type(6'h05, rs, rt, boff);
            13: return j_type(int'($urandom_range(0, IMEM_DEPTH - 1)));
            14: return r_type(6'h21, rs, rt, rd);        // unsupported funct
            default: return {6'h3F, r[25:0]};            // unsupported opcode
        endcase
    endfunction

    // Watchdog: the run is short; reaching this means something stalled.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // ---- Reset and first fetch ----
        clear_state();
        set_instr(0, r_type(6'h20, 1, 2, 3));
        set_reg(1, 32'd5);
        set_reg(2, 32'd7);
        leave_reset(2);
        step(1);
        check("first_add_r3", dut.RB.MEM[3], 32'd12);
        check("first_pc", pc_out, 32'h4);

        // ---- ALU ops, immediates, memory, $0 ----
        enter_reset();
        clear_state();
        set_reg(1, 32'hFFFF_FFFF);
        set_reg(2, 32'd1);
        set_instr(0,  r_type(6'h22, 1, 2, 4));
        set_instr(1,  r_type(6'h24, 1, 2, 5));
        set_instr(2,  r_type(6'h25, 1, 2, 6));
        set_instr(3,  r_type(6'h2A, 1, 2, 7));
        set_instr(4,  r_type(6'h20, 1, 2, 12));
        set_instr(5,  i_type(6'h08, 0, 8, -3));
        set_instr(6,  i_type(6'h0D, 0, 9, 16'h8000));
        set_instr(7,  i_type(6'h0A, 8, 10, 0));
        set_instr(8,  i_type(6'h2B, 0, 1, 8));
        set_instr(9,  i_type(6'h23, 0, 11, 8));
        set_instr(10, r_type(6'h20, 1, 1, 0));
        leave_reset(2);
        step(11);
        check("sub_r4",  dut.RB.MEM[4],  32'hFFFF_FFFE);
        check("and_r5",  dut.RB.MEM[5],  32'h0000_0001);
        check("or_r6",   dut.RB.MEM[6],  32'hFFFF_FFFF);
        check("slt_r7",  dut.RB.MEM[7],  32'h0000_0001);
        check("add_wrap_r12", dut.RB.MEM[12], 32'h0000_0000);
        check("addi_r8", dut.RB.MEM[8],  32'hFFFF_FFFD);
        check("ori_r9",  dut.RB.MEM[9],  32'h0000_8000);
        check("slti_r10", dut.RB.MEM[10], 32'h0000_0001);
        check("sw_dmem2", dut.DataMem.MEM[2], 32'hFFFF_FFFF);
        check("lw_r11",  dut.RB.MEM[11], 32'hFFFF_FFFF);
        check("r0_zero", dut.RB.MEM[0],  32'h0000_0000);
        compare_state("alu");

        // ---- Control flow ----
        enter_reset();
        clear_state();
        set_reg(1, 32'h1234_5678);
        set_instr(0, j_type(4));
        set_instr(4, i_type(6'h04, 0, 0, 2));
        set_instr(7, i_type(6'h05, 0, 0, 2));
        set_instr(8, 32'hFC00_0000);
        leave_reset(2);
        step(1); check("j_pc",    pc_out, 32'h10);
        step(1); check("beq_pc",  pc_out, 32'h1C);
        step(1); check("bne_pc",  pc_out, 32'h20);
        step(1); check("undef_pc", pc_out, 32'h24);
        compare_state("cf");

        // ---- Reset while a store sits at PC ----
        enter_reset();
        clear_state();
        set_dmem(4, 32'h0000_DEAD);
        set_instr(0, i_type(6'h08, 0, 1, 16'h55));
        set_instr(1, i_type(6'h2B, 0, 1, 16));
        leave_reset(1);
        step(1);
        check("sw_at_pc", instr_out, i_type(6'h2B, 0, 1, 16));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dmem", dut.DataMem.MEM[4], 32'h0000_DEAD);
        check("midrst_pc", pc_out, 32'd0);
        rst  = 1'b0;
        m_pc = 32'd0;
        step(2);
        check("rerun_dmem", dut.DataMem.MEM[4], 32'h0000_0055);

        // ---- Random programs ----
        for (int round = 0; round < 3; round++) begin
            enter_reset();
            for (int i = 0; i < IMEM_DEPTH; i++) set_instr(i, rand_instr());
            set_reg(0, 32'd0);
            for (int i = 1; i < 32; i++)         set_reg(i, $urandom);
            for (int i = 0; i < DMEM_DEPTH; i++) set_dmem(i, $urandom);
            leave_reset(2);
            step(200);
            compare_state($sformatf("rnd%0d", round));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
